// File: rtl/bloom_filter_ingress.sv
// rtl/bloom_filter_ingress.sv - Avalon-ST framing guard ahead of bloom_filter; counters enabled by BLOOM_FILTER_INGRESS_STATS_EN
package bloom_filter_pkg;
    localparam int BYTE_W = 8;
endpackage

module bloom_filter_ingress
    import bloom_filter_pkg::*;
#(
    parameter int SYMBOLS   = 8,
    parameter int EMPTY_W   = (SYMBOLS > 1) ? $clog2(SYMBOLS) : 1,
    parameter int MAX_BEATS = 190,
    parameter int CNT_W     = 32
) (
    input  logic                        main_clk_i,
    input  logic                        main_arst_n_i,
    input  logic [SYMBOLS*BYTE_W-1:0]   in_data_i,
    input  logic                        in_valid_i,
    output logic                        in_ready_o,
    input  logic                        in_startofpacket_i,
    input  logic                        in_endofpacket_i,
    input  logic [EMPTY_W-1:0]          in_empty_i,
    output logic [SYMBOLS*BYTE_W-1:0]   out_data_o,
    output logic                        out_valid_o,
    output logic                        out_startofpacket_o,
    output logic                        out_endofpacket_o,
    output logic [EMPTY_W-1:0]          out_empty_o,
    input  logic                        out_ready_i,
    input  logic                        stat_clr_i,
    output logic [CNT_W-1:0]            stat_pkt_o,
    output logic [CNT_W-1:0]            stat_drop_beat_o,
    output logic [CNT_W-1:0]            stat_trunc_o
);

    localparam int DATA_W = SYMBOLS * BYTE_W;
    localparam int BC_W   = $clog2(MAX_BEATS + 1);
    localparam logic [BC_W-1:0] MAX_BC = BC_W'(MAX_BEATS);

    typedef enum logic [1:0] {IDLE, IN_PKT, DROP} state_t;

    state_t              state_q, state_d;
    logic [BC_W-1:0]     cnt_q, cnt_d;
    logic                h_valid, h_sop, h_eop;
    logic [DATA_W-1:0]   h_data;
    logic [EMPTY_W-1:0]  h_empty;

    logic accept, abort, out_xfer;
    logic store, force_eop, drop_inc, trunc_inc, pkt_inc;

    assign in_ready_o = !h_valid || out_ready_i;
    assign accept     = in_valid_i && in_ready_o;
    // A SOP arriving behind a non-EOP beat closes that beat on the way out.
    assign abort      = h_valid && !h_eop && in_valid_i && in_startofpacket_i;

    assign out_valid_o         = h_valid && (h_eop || in_valid_i);
    assign out_data_o          = h_data;
    assign out_startofpacket_o = h_valid && h_sop;
    assign out_endofpacket_o   = h_valid && (h_eop || abort);
    assign out_empty_o         = abort ? '0 : h_empty;
    assign out_xfer            = out_valid_o && out_ready_i;
    assign pkt_inc             = out_xfer && out_endofpacket_o;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        store     = 1'b0;
        force_eop = 1'b0;
        drop_inc  = 1'b0;
        trunc_inc = 1'b0;
        if (accept) begin
            case (state_q)
                IN_PKT: begin
                    store = 1'b1;
                    if (in_startofpacket_i) begin
                        trunc_inc = 1'b1;
                        cnt_d     = BC_W'(1);
                        state_d   = in_endofpacket_i ? IDLE : IN_PKT;
                    end else begin
                        cnt_d = cnt_q + BC_W'(1);
                        if (in_endofpacket_i) begin
                            state_d = IDLE;
                        end else if (cnt_q + BC_W'(1) == MAX_BC) begin
                            force_eop = 1'b1;
                            trunc_inc = 1'b1;
                            state_d   = DROP;
                        end
                    end
                end
                default: begin
                    if (in_startofpacket_i) begin
                        store   = 1'b1;
                        cnt_d   = BC_W'(1);
                        state_d = in_endofpacket_i ? IDLE : IN_PKT;
                    end else begin
                        drop_inc = 1'b1;
                        state_d  = in_endofpacket_i ? IDLE : DROP;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge main_clk_i or negedge main_arst_n_i) begin
        if (!main_arst_n_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge main_clk_i or negedge main_arst_n_i) begin
        if (!main_arst_n_i) begin
            h_valid <= 1'b0;
            h_sop   <= 1'b0;
            h_eop   <= 1'b0;
            h_data  <= '0;
            h_empty <= '0;
        end else if (store) begin
            h_valid <= 1'b1;
            h_sop   <= in_startofpacket_i;
            h_eop   <= in_endofpacket_i || force_eop;
            h_data  <= in_data_i;
            h_empty <= in_endofpacket_i ? in_empty_i : '0;
        end else if (out_xfer) begin
            h_valid <= 1'b0;
        end
    end

`ifdef BLOOM_FILTER_INGRESS_STATS_EN
    logic [CNT_W-1:0] pkt_q, drop_q, trunc_q;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    always_ff @(posedge main_clk_i or negedge main_arst_n_i) begin
        if (!main_arst_n_i) begin
            pkt_q   <= '0;
            drop_q  <= '0;
            trunc_q <= '0;
        end else if (stat_clr_i) begin
            pkt_q   <= '0;
            drop_q  <= '0;
            trunc_q <= '0;
        end else begin
            if (pkt_inc)   pkt_q   <= sat_inc(pkt_q);
            if (drop_inc)  drop_q  <= sat_inc(drop_q);
            if (trunc_inc) trunc_q <= sat_inc(trunc_q);
        end
    end

    assign stat_pkt_o       = pkt_q;
    assign stat_drop_beat_o = drop_q;
    assign stat_trunc_o     = trunc_q;
`else
    logic stats_unused;
    assign stats_unused     = ^{stat_clr_i, pkt_inc, drop_inc, trunc_inc};
    assign stat_pkt_o       = '0;
    assign stat_drop_beat_o = '0;
    assign stat_trunc_o     = '0;
`endif

endmodule

// File: tb/tb_bloom_filter_ingress.sv
// tb/tb_bloom_filter_ingress.sv - directed bench for bloom_filter_ingress (MAX_BEATS=4)
module tb_bloom_filter_ingress;

`ifdef BLOOM_FILTER_INGRESS_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    typedef struct packed {
        logic [63:0] d;
        logic        s;
        logic        e;
        logic [2:0]  m;
    } beat_t;

    logic        clk;
    logic        rst_n;
    logic [63:0] in_data;
    logic        in_valid, in_ready, in_sop, in_eop;
    logic [2:0]  in_empty;
    logic [63:0] out_data;
    logic        out_valid, out_sop, out_eop, out_ready;
    logic [2:0]  out_empty;
    logic        stat_clr;
    logic [31:0] stat_pkt, stat_drop, stat_trunc;

    int n_vec = 0;
    int n_err = 0;
    beat_t obs[$];

    bloom_filter_ingress #(
        .SYMBOLS(8), .EMPTY_W(3), .MAX_BEATS(4), .CNT_W(32)
    ) dut (
        .main_clk_i(clk),
        .main_arst_n_i(rst_n),
        .in_data_i(in_data),
        .in_valid_i(in_valid),
        .in_ready_o(in_ready),
        .in_startofpacket_i(in_sop),
        .in_endofpacket_i(in_eop),
        .in_empty_i(in_empty),
        .out_data_o(out_data),
        .out_valid_o(out_valid),
        .out_startofpacket_o(out_sop),
        .out_endofpacket_o(out_eop),
        .out_empty_o(out_empty),
        .out_ready_i(out_ready),
        .stat_clr_i(stat_clr),
        .stat_pkt_o(stat_pkt),
        .stat_drop_beat_o(stat_drop),
        .stat_trunc_o(stat_trunc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready)
            obs.push_back({out_data, out_sop, out_eop, out_empty});
    end

    function automatic beat_t mk(input logic [63:0] d, input logic s, input logic e, input logic [2:0] m);
        return {d, s, e, m};
    endfunction

    task automatic drive(input logic v, input logic s, input logic e, input logic [63:0] d,
                         input logic [2:0] m, input logic r);
        in_valid  = v;
        in_sop    = s;
        in_eop    = e;
        in_data   = d;
        in_empty  = m;
        out_ready = r;
    endtask

    task automatic cyc(input logic v, input logic s, input logic e, input logic [63:0] d,
                       input logic [2:0] m, input logic r);
        drive(v, s, e, d, m, r);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 64'h0, 3'd0, 1'b1);
    endtask

    task automatic clear_all();
        stat_clr = 1'b1;
        idle(1);
        stat_clr = 1'b0;
        obs.delete();
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        stat_clr = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 64'h0, 3'd0, 1'b1);
        #12;
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        n_vec++; if ({out_sop, out_eop} !== 2'b00) begin n_err++; $display("FAIL reset_sop_eop got=%b exp=00", {out_sop, out_eop}); end
        n_vec++; if (out_data !== 64'h0) begin n_err++; $display("FAIL reset_data got=%h exp=0", out_data); end
        n_vec++; if (out_empty !== 3'd0) begin n_err++; $display("FAIL reset_empty got=%0d exp=0", out_empty); end
        n_vec++; if ({stat_pkt, stat_drop, stat_trunc} !== 96'h0) begin n_err++; $display("FAIL reset_stats got=%h exp=0", {stat_pkt, stat_drop, stat_trunc}); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(2);
    endtask

    task automatic test_clean();
        beat_t ex[$];
        clear_all();
        cyc(1'b1, 1'b1, 1'b0, 64'hC1C1_0000_0000_0001, 3'd0, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 64'hC1C1_0000_0000_0002, 3'd0, 1'b1);
        cyc(1'b1, 1'b0, 1'b1, 64'hC1C1_0000_0000_0003, 3'd5, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 64'h0, 3'd0, 1'b1);
        @(negedge clk);
        n_vec++; if ({out_valid, out_eop} !== 2'b11) begin n_err++; $display("FAIL clean_eop_latency got=%b exp=11", {out_valid, out_eop}); end
        @(posedge clk); #1;
        idle(2);
        ex.push_back(mk(64'hC1C1_0000_0000_0001, 1'b1, 1'b0, 3'd0));
        ex.push_back(mk(64'hC1C1_0000_0000_0002, 1'b0, 1'b0, 3'd0));
        ex.push_back(mk(64'hC1C1_0000_0000_0003, 1'b0, 1'b1, 3'd5));
        n_vec++; if (obs.size() !== ex.size()) begin n_err++; $display("FAIL clean_count got=%0d exp=%0d", obs.size(), ex.size()); end
        for (int i = 0; i < ex.size(); i++) begin
            n_vec++;
            if (((i < obs.size()) ? obs[i] : '0) !== ex[i]) begin
                n_err++; $display("FAIL clean_beat%0d got=%h exp=%h", i, (i < obs.size()) ? obs[i] : '0, ex[i]);
            end
        end
        n_vec++; if (stat_pkt !== (STATS ? 32'd1 : 32'd0)) begin n_err++; $display("FAIL clean_stat_pkt got=%0d exp=%0d", stat_pkt, STATS ? 1 : 0); end
        n_vec++; if ({stat_drop, stat_trunc} !== 64'h0) begin n_err++; $display("FAIL clean_stat_other got=%h exp=0", {stat_drop, stat_trunc}); end
    endtask

    task automatic test_orphans();
        clear_all();
        cyc(1'b1, 1'b0, 1'b0, 64'h0DD0_0000_0000_0001, 3'd2, 1'b1);
        cyc(1'b1, 1'b0, 1'b1, 64'h0DD0_0000_0000_0002, 3'd4, 1'b1);
        idle(2);
        n_vec++; if (obs.size() !== 0) begin n_err++; $display("FAIL orphan_count got=%0d exp=0", obs.size()); end
        n_vec++; if (stat_drop !== (STATS ? 32'd2 : 32'd0)) begin n_err++; $display("FAIL orphan_stat_drop got=%0d exp=%0d", stat_drop, STATS ? 2 : 0); end
        cyc(1'b1, 1'b1, 1'b1, 64'h0DD0_0000_0000_0003, 3'd1, 1'b1);
        idle(2);
        n_vec++; if (obs.size() !== 1) begin n_err++; $display("FAIL orphan_follow_count got=%0d exp=1", obs.size()); end
        n_vec++;
        if (((obs.size() > 0) ? obs[0] : '0) !== mk(64'h0DD0_0000_0000_0003, 1'b1, 1'b1, 3'd1)) begin
            n_err++; $display("FAIL orphan_follow_beat got=%h exp=%h", (obs.size() > 0) ? obs[0] : '0, mk(64'h0DD0_0000_0000_0003, 1'b1, 1'b1, 3'd1));
        end
    endtask

    task automatic test_abort();
        beat_t ex[$];
        clear_all();
        cyc(1'b1, 1'b1, 1'b0, 64'hAB00_0000_0000_00A1, 3'd0, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 64'hAB00_0000_0000_00A2, 3'd6, 1'b1);
        cyc(1'b1, 1'b1, 1'b1, 64'hAB00_0000_0000_00B1, 3'd3, 1'b1);
        idle(2);
        ex.push_back(mk(64'hAB00_0000_0000_00A1, 1'b1, 1'b0, 3'd0));
        ex.push_back(mk(64'hAB00_0000_0000_00A2, 1'b0, 1'b1, 3'd0));
        ex.push_back(mk(64'hAB00_0000_0000_00B1, 1'b1, 1'b1, 3'd3));
        n_vec++; if (obs.size() !== ex.size()) begin n_err++; $display("FAIL abort_count got=%0d exp=%0d", obs.size(), ex.size()); end
        for (int i = 0; i < ex.size(); i++) begin
            n_vec++;
            if (((i < obs.size()) ? obs[i] : '0) !== ex[i]) begin
                n_err++; $display("FAIL abort_beat%0d got=%h exp=%h", i, (i < obs.size()) ? obs[i] : '0, ex[i]);
            end
        end
        n_vec++; if (stat_trunc !== (STATS ? 32'd1 : 32'd0)) begin n_err++; $display("FAIL abort_stat_trunc got=%0d exp=%0d", stat_trunc, STATS ? 1 : 0); end
        n_vec++; if (stat_pkt !== (STATS ? 32'd2 : 32'd0)) begin n_err++; $display("FAIL abort_stat_pkt got=%0d exp=%0d", stat_pkt, STATS ? 2 : 0); end
    endtask

    task automatic test_overlength();
        beat_t ex[$];
        clear_all();
        cyc(1'b1, 1'b1, 1'b0, 64'h0E00_0000_0000_0001, 3'd0, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 64'h0E00_0000_0000_0002, 3'd0, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 64'h0E00_0000_0000_0003, 3'd0, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 64'h0E00_0000_0000_0004, 3'd2, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 64'h0E00_0000_0000_0005, 3'd0, 1'b1);
        cyc(1'b1, 1'b0, 1'b1, 64'h0E00_0000_0000_0006, 3'd7, 1'b1);
        idle(2);
        ex.push_back(mk(64'h0E00_0000_0000_0001, 1'b1, 1'b0, 3'd0));
        ex.push_back(mk(64'h0E00_0000_0000_0002, 1'b0, 1'b0, 3'd0));
        ex.push_back(mk(64'h0E00_0000_0000_0003, 1'b0, 1'b0, 3'd0));
        ex.push_back(mk(64'h0E00_0000_0000_0004, 1'b0, 1'b1, 3'd0));
        n_vec++; if (obs.size() !== ex.size()) begin n_err++; $display("FAIL overlen_count got=%0d exp=%0d", obs.size(), ex.size()); end
        for (int i = 0; i < ex.size(); i++) begin
            n_vec++;
            if (((i < obs.size()) ? obs[i] : '0) !== ex[i]) begin
                n_err++; $display("FAIL overlen_beat%0d got=%h exp=%h", i, (i < obs.size()) ? obs[i] : '0, ex[i]);
            end
        end
        n_vec++; if (stat_drop !== (STATS ? 32'd2 : 32'd0)) begin n_err++; $display("FAIL overlen_stat_drop got=%0d exp=%0d", stat_drop, STATS ? 2 : 0); end
        n_vec++; if (stat_trunc !== (STATS ? 32'd1 : 32'd0)) begin n_err++; $display("FAIL overlen_stat_trunc got=%0d exp=%0d", stat_trunc, STATS ? 1 : 0); end
        n_vec++; if (stat_pkt !== (STATS ? 32'd1 : 32'd0)) begin n_err++; $display("FAIL overlen_stat_pkt got=%0d exp=%0d", stat_pkt, STATS ? 1 : 0); end
    endtask

    task automatic test_back_to_back();
        beat_t ex[$];
        clear_all();
        drive(1'b1, 1'b1, 1'b0, 64'hBB00_0000_0000_0001, 3'd0, 1'b1);
        @(negedge clk);
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready_empty got=%b exp=1", in_ready); end
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b0, 64'h0, 3'd0, 1'b1);
        @(negedge clk);
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_stalled_valid got=%b exp=0", out_valid); end
        @(posedge clk); #1;
        for (int c = 0; c < 3; c++) begin
            drive(1'b1, 1'b0, 1'b0, 64'hBB00_0000_0000_0002, 3'd0, (c == 2));
            @(negedge clk);
            n_vec++; if (in_ready !== (c == 2)) begin n_err++; $display("FAIL bp_ready_track%0d got=%b exp=%b", c, in_ready, (c == 2)); end
            n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_held_valid%0d got=%b exp=1", c, out_valid); end
            @(posedge clk); #1;
        end
        cyc(1'b1, 1'b0, 1'b0, 64'hBB00_0000_0000_0003, 3'd0, 1'b1);
        cyc(1'b1, 1'b0, 1'b1, 64'hBB00_0000_0000_0004, 3'd1, 1'b1);
        idle(2);
        ex.push_back(mk(64'hBB00_0000_0000_0001, 1'b1, 1'b0, 3'd0));
        ex.push_back(mk(64'hBB00_0000_0000_0002, 1'b0, 1'b0, 3'd0));
        ex.push_back(mk(64'hBB00_0000_0000_0003, 1'b0, 1'b0, 3'd0));
        ex.push_back(mk(64'hBB00_0000_0000_0004, 1'b0, 1'b1, 3'd1));
        n_vec++; if (obs.size() !== ex.size()) begin n_err++; $display("FAIL bp_count got=%0d exp=%0d", obs.size(), ex.size()); end
        for (int i = 0; i < ex.size(); i++) begin
            n_vec++;
            if (((i < obs.size()) ? obs[i] : '0) !== ex[i]) begin
                n_err++; $display("FAIL bp_beat%0d got=%h exp=%h", i, (i < obs.size()) ? obs[i] : '0, ex[i]);
            end
        end
        n_vec++; if (stat_pkt !== (STATS ? 32'd1 : 32'd0)) begin n_err++; $display("FAIL bp_stat_pkt got=%0d exp=%0d", stat_pkt, STATS ? 1 : 0); end
    endtask

    task automatic test_reset_mid();
        clear_all();
        cyc(1'b1, 1'b1, 1'b0, 64'hEE00_0000_0000_0001, 3'd0, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 64'hEE00_0000_0000_0002, 3'd0, 1'b1);
        drive(1'b1, 1'b0, 1'b0, 64'hEE00_0000_0000_0003, 3'd0, 1'b1);
        rst_n = 1'b0;
        #1;
        n_vec++; if ({in_ready, out_valid, out_sop, out_eop} !== 4'b1000) begin n_err++; $display("FAIL rstmid_ctrl got=%b exp=1000", {in_ready, out_valid, out_sop, out_eop}); end
        n_vec++; if ({out_data, out_empty} !== 67'h0) begin n_err++; $display("FAIL rstmid_data got=%h exp=0", {out_data, out_empty}); end
        n_vec++; if ({stat_pkt, stat_drop, stat_trunc} !== 96'h0) begin n_err++; $display("FAIL rstmid_stats got=%h exp=0", {stat_pkt, stat_drop, stat_trunc}); end
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        cyc(1'b1, 1'b0, 1'b0, 64'hEE00_0000_0000_0003, 3'd0, 1'b1);
        cyc(1'b1, 1'b0, 1'b1, 64'hEE00_0000_0000_0004, 3'd2, 1'b1);
        idle(2);
        n_vec++; if (obs.size() !== 1) begin n_err++; $display("FAIL rstmid_count got=%0d exp=1", obs.size()); end
        n_vec++;
        if (((obs.size() > 0) ? obs[0] : '0) !== mk(64'hEE00_0000_0000_0001, 1'b1, 1'b0, 3'd0)) begin
            n_err++; $display("FAIL rstmid_beat0 got=%h exp=%h", (obs.size() > 0) ? obs[0] : '0, mk(64'hEE00_0000_0000_0001, 1'b1, 1'b0, 3'd0));
        end
        n_vec++; if (stat_drop !== (STATS ? 32'd2 : 32'd0)) begin n_err++; $display("FAIL rstmid_stat_drop got=%0d exp=%0d", stat_drop, STATS ? 2 : 0); end
        n_vec++; if ({stat_pkt, stat_trunc} !== 64'h0) begin n_err++; $display("FAIL rstmid_stat_other got=%h exp=0", {stat_pkt, stat_trunc}); end
    endtask

    initial begin
        test_reset();
        test_clean();
        test_orphans();
        test_abort();
        test_overlength();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
